// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller: branch/jump redirect, data-memory request/ready handshake
// with timeout, pipeline stall generation and the MEM/WB pipeline register.
module mem_stage_ctrl #(
    parameter int DW      = 32,
    parameter int TIMEOUT = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          zero_mem,
    input  logic [2:0]    wb_in,
    input  logic [3:0]    m_in,
    input  logic [4:0]    rd_in,
    input  logic [DW-1:0] alu_in,
    input  logic [DW-1:0] wd_in,
    input  logic [DW-1:0] branch_pc_in,
    input  logic [DW-1:0] pc_in,
    input  logic [DW-1:0] jump_addr_in,
    output logic          dmem_req,
    output logic          dmem_we,
    output logic [DW-1:0] dmem_addr,
    output logic [DW-1:0] dmem_wdata,
    input  logic [DW-1:0] dmem_rdata,
    input  logic          dmem_ready,
    output logic          mem_stall,
    output logic [1:0]    pc_src,
    output logic [DW-1:0] pc_target,
    output logic          flush,
    output logic [2:0]    wb_out,
    output logic [4:0]    rd_out,
    output logic [DW-1:0] alu_out,
    output logic [DW-1:0] mdata_out,
    output logic [DW-1:0] pc_out,
    output logic          mem_err
);

    typedef enum logic {ST_IDLE, ST_WAIT} state_t;

    localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

    state_t     state;
    logic [7:0] cnt;
    logic       memop;
    logic       done;
    logic       abort;
    logic       rd_cpl;

    always_comb begin
        memop      = m_in[1] | m_in[0];
        done       = (state == ST_WAIT) && dmem_ready;
        abort      = (state == ST_WAIT) && !dmem_ready && (cnt == LAST);
        rd_cpl     = done && m_in[1] && !m_in[0];
        dmem_req   = (state == ST_WAIT) || memop;
        dmem_we    = dmem_req & m_in[0];
        dmem_addr  = alu_in;
        dmem_wdata = wd_in;
        // dmem_ready is ignored in IDLE, so a memop always stalls at least once
        mem_stall  = (state == ST_IDLE) ? memop : !(dmem_ready || abort);
    end

    // Redirect only once the instruction leaves MEM, never while it is held
    always_comb begin
        pc_src    = 2'b00;
        pc_target = pc_in;
        if (!mem_stall) begin
            if (m_in[3]) begin
                pc_src    = 2'b10;
                pc_target = jump_addr_in;
            end else if (m_in[2] && zero_mem) begin
                pc_src    = 2'b01;
                pc_target = branch_pc_in;
            end
        end
        flush = (pc_src != 2'b00);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            mem_err   <= 1'b0;
            wb_out    <= '0;
            rd_out    <= '0;
            alu_out   <= '0;
            mdata_out <= '0;
            pc_out    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (memop) begin
                        state <= ST_WAIT;
                        cnt   <= '0;
                    end
                end
                ST_WAIT: begin
                    if (dmem_ready) begin
                        state <= ST_IDLE;
                    end else if (abort) begin
                        state   <= ST_IDLE;
                        mem_err <= 1'b1;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase

            // Stalled or aborted accesses enter write-back as a bubble
            wb_out    <= (mem_stall || abort) ? 3'b000 : wb_in;
            rd_out    <= rd_in;
            alu_out   <= alu_in;
            pc_out    <= pc_in;
            mdata_out <= rd_cpl ? dmem_rdata : '0;
        end
    end

endmodule

// File: doc/mem_stage_ctrl.md
Name: mem_stage_ctrl

Overview:
- MEM-stage consumer of the EX/MEM pipeline bundle.
- Resolves branch/jump redirect and drives the data-memory request/ready handshake for loads and stores.
- Stalls the front of the pipeline while a memory access is outstanding.
- Owns the MEM/WB pipeline register feeding write-back.

Parameters:
- DW, 32, datapath width (ALU result, store data, load data, PCs).
- TIMEOUT, 64, maximum cycles in WAIT before the access is aborted (range 2..255).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- zero_mem  in  1  ALU zero flag from EX/MEM
- wb_in  in  3  WB control: [2]=RegWrite, [1]=MemtoReg, [0]=Link
- m_in  in  4  M control: [3]=Jump, [2]=Branch, [1]=MemRead, [0]=MemWrite
- rd_in  in  5  destination register from EX/MEM
- alu_in  in  DW  ALU result, which is also the memory address
- wd_in  in  DW  store data
- branch_pc_in  in  DW  branch target
- pc_in  in  DW  PC+4 of the instruction
- jump_addr_in  in  DW  jump target
- dmem_req  out  1  memory request
- dmem_we  out  1  write enable, valid with dmem_req
- dmem_addr  out  DW  equals alu_in
- dmem_wdata  out  DW  equals wd_in
- dmem_rdata  in  DW  load data, valid with dmem_ready
- dmem_ready  in  1  access complete
- mem_stall  out  1  hold PC, IF/ID, ID/EX, EX/MEM
- pc_src  out  2  00 sequential, 01 branch, 10 jump
- pc_target  out  DW  redirect target
- flush  out  1  squash IF/ID and ID/EX
- wb_out  out  3  MEM/WB WB control
- rd_out  out  5  MEM/WB destination
- alu_out  out  DW  MEM/WB ALU result
- mdata_out  out  DW  MEM/WB load data
- pc_out  out  DW  MEM/WB PC+4 (link value)
- mem_err  out  1  sticky timeout flag

Behaviour:
- Reset is synchronous, active-high. On reset, every registered output clears to 0: wb_out, rd_out, alu_out, mdata_out, pc_out, mem_err. The state machine returns to IDLE and the wait counter clears to 0.
- A reset while in WAIT drops dmem_req in the next cycle. No MEM/WB write occurs for the aborted access.
- memop = m_in[1] | m_in[0]. If both bits are set, the access is treated as a write (dmem_we=1).
- State machine, IDLE:
  - If memop: dmem_req=1, mem_stall=1, next state WAIT, wait counter=0.
  - dmem_ready is ignored in IDLE, so memory latency is at least 1 cycle.
- State machine, WAIT:
  - dmem_req=1, with address, write data and we held stable.
  - If dmem_ready: mem_stall=0 in that same cycle, next state IDLE, and MEM/WB captures at this edge (mdata_out=dmem_rdata for reads).
  - Otherwise mem_stall=1 and the wait counter increments.
  - If the counter reaches TIMEOUT-1 without dmem_ready: set mem_err (sticky until reset), deassert stall, return to IDLE, and load a bubble into MEM/WB.
- MEM/WB register, every edge:
  - When mem_stall=1: load a bubble (wb_out=0). Other fields may update and are don't-care.
  - Otherwise: load wb_in, rd_in, alu_in, pc_in, and mdata_out (dmem_rdata for a completing read, else 0).
  - Latency for non-memory instructions is 1 cycle.
- Redirect (combinational from the EX/MEM bundle):
  - jump = m_in[3]; taken = m_in[2] & zero_mem.
  - Jump has priority over branch: pc_src=10, pc_target=jump_addr_in.
  - Else if taken: pc_src=01, pc_target=branch_pc_in.
  - Else pc_src=00, pc_target=pc_in.
  - flush = jump | taken.
  - Redirect is gated by !mem_stall: a memop carrying stray Jump/Branch bits redirects only in its completing cycle.
- A stored value of dmem_rdata that changes outside a dmem_ready cycle has no effect.

Test Plan:
- Reset mid-WAIT: assert rst while a load is outstanding -> next cycle dmem_req=0 and all outputs 0; a dmem_ready arriving after reset causes no write.
- ALU op: wb_in=100, alu_in=0x0000_002A, rd_in=5, no memop -> one cycle later wb_out=100, alu_out=0x2A, rd_out=5; mem_stall never asserts.
- Load, ready after 3 WAIT cycles with dmem_rdata=0xDEAD_BEEF -> dmem_req high for 4 cycles, mem_stall high for 3 cycles, wb_out=0 during the stall, then wb_out=110 and mdata_out=0xDEAD_BEEF.
- Store to addr 0x100, data 0x55, ready after 1 WAIT cycle -> dmem_we=1, dmem_addr=0x100, dmem_wdata=0x55; MEM/WB gets wb_out=000.
- Branch m_in=0100 with zero_mem=1, branch_pc_in=0x40 -> pc_src=01, pc_target=0x40, flush=1; same with zero_mem=0 -> pc_src=00, flush=0. Jump and branch together with jump_addr_in=0x80 -> pc_src=10, pc_target=0x80.
- Timeout: TIMEOUT=4, load with dmem_ready never asserted -> mem_err=1 after 4 stalled cycles, then mem_stall=0, bubble loaded into MEM/WB, state returns to IDLE, and mem_err stays 1 until rst.
